// File: rtl/serial_arb_pkg.sv
// serial_arb_pkg: shared state encoding and preamble constants for the serial link arbiter
package serial_arb_pkg;
  typedef enum logic [1:0] {IDLE, PRE, DATA, DONE} state_t;
  localparam int PRE_LEN = 3;
  localparam logic [PRE_LEN-1:0] PREAMBLE = 3'b100;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the lowest requester at or above ptr, wrapping to 0
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            any
);
  function automatic int rot(input logic [PW-1:0] p, input int i);
    int j;
    j = int'(p) + i;
    return (j >= NREQ) ? j - NREQ : j;
  endfunction
  // scan from the farthest offset down so the nearest requester at or above ptr wins
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[rot(ptr, i)]) win = PW'(rot(ptr, i));
  end
  assign any = |req;
endmodule

// File: rtl/serial_link_arbiter.sv
// serial_link_arbiter: round-robin owner of a shared serial line sending preamble + LSB-first payload frames
module serial_link_arbiter
  import serial_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] data,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic                   ser_out,
  output logic                   ser_valid,
  output logic                   busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (DATA_W > PRE_LEN) ? DATA_W : PRE_LEN;
  localparam int CW = $clog2(MAXC);
  localparam logic [3:0] PRE_BITS = {1'b1, PREAMBLE};
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr, owner, win;
  logic [DATA_W-1:0] sh;
  logic any, last;
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req(req),
    .ptr(ptr),
    .win(win),
    .any(any)
  );
  // state register; reset aborts any frame immediately
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next state and outputs decoded from state, counter, owner and shift register only
  always_comb begin
    last = (state == PRE) ? (cnt == CW'(PRE_LEN - 1)) : (cnt == CW'(DATA_W - 1));
    nxt = (state == IDLE) ? (any ? PRE : IDLE) :
          (state == PRE)  ? (last ? DATA : PRE) :
          (state == DATA) ? (last ? DONE : DATA) : IDLE;
    busy = state != IDLE;
    grant = busy ? NREQ'(1) << owner : '0;
    done = (state == DONE) ? NREQ'(1) << owner : '0;
    ser_valid = (state == PRE) || (state == DATA);
    ser_out = (state == PRE) ? PRE_BITS[cnt[1:0]] : (state == DATA) ? sh[0] : 1'b1;
  end
  // per-state counter, payload capture at grant, and pointer advance past the finished owner
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      sh <= '0;
      owner <= '0;
      ptr <= '0;
    end else begin
      cnt <= (nxt == state && state != IDLE) ? cnt + 1'b1 : '0;
      if (state == IDLE && any) begin
        owner <= win;
        sh <= data[DATA_W*win +: DATA_W];
      end else if (state == DATA) sh <= sh >> 1;
      if (state == DONE) ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end
endmodule

// File: tb/tb_serial_link_arbiter.sv
// tb_serial_link_arbiter: table-driven frame checks, corner sequences and a randomized frame-level model
module tb_serial_link_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DW-1:0] data = '0;
  logic [NREQ-1:0] grant, done;
  logic ser_out, ser_valid, busy;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          owner;
    logic [7:0]  pay;
    bit          chg;
  } vec_t;
  typedef struct packed {
    logic so;
    logic sv;
    logic [3:0] g;
    logic [3:0] d;
    logic b;
  } obs_t;
  vec_t tbl[12];
  obs_t q[$];
  int ptr_m;
  always #5 clk = ~clk;
  serial_link_arbiter #(.NREQ(NREQ), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .data(data),
    .grant(grant),
    .done(done),
    .ser_out(ser_out),
    .ser_valid(ser_valid),
    .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask
  task automatic chk_idle(input string name);
    chk(name, {ser_out, ser_valid, busy, grant, done}, {1'b1, 1'b0, 1'b0, 8'h00});
  endtask
  task automatic run_frame(input vec_t v);
    int w;
    logic [3:0] oh;
    logic [10:0] bits;
    req = v.req;
    data = v.data;
    oh = 4'b1 << v.owner;
    bits = {v.pay, 3'b100};
    w = 0;
    @(negedge clk);
    while (grant == 0 && w < 20) begin
      w++;
      @(negedge clk);
    end
    chk("latency", w, 0);
    for (int k = 0; k < 12; k++) begin
      chk("grant", grant, oh);
      chk("ser_out", ser_out, (k < 11) ? bits[k] : 1'b1);
      chk("ser_valid", ser_valid, k < 11);
      chk("done", done, (k == 11) ? oh : 4'b0);
      if (v.chg && k == 5) begin
        req = '0;
        data = '1;
      end
      @(negedge clk);
    end
    chk_idle("gap_idle");
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    obs_t e, idle_o;
    int w, n;
    logic [3:0] oh;
    logic [7:0] pay;
    logic [3:0] pre;
    idle_o = obs_t'({1'b1, 1'b0, 4'b0, 4'b0, 1'b0});
    pre = 4'b0100;
    tbl[0]  = '{4'b0010, 32'hD4C3A5B2, 1, 8'hA5, 1'b0};
    tbl[1]  = '{4'b0011, 32'hD4C3A5B2, 0, 8'hB2, 1'b0};
    tbl[2]  = '{4'b1001, 32'hD4C3A5B2, 3, 8'hD4, 1'b0};
    tbl[3]  = '{4'b1111, 32'hD4C3A5B2, 0, 8'hB2, 1'b0};
    tbl[4]  = '{4'b1111, 32'hD4C3A5B2, 1, 8'hA5, 1'b0};
    tbl[5]  = '{4'b1111, 32'hD4C3A5B2, 2, 8'hC3, 1'b0};
    tbl[6]  = '{4'b1111, 32'hD4C3A5B2, 3, 8'hD4, 1'b0};
    tbl[7]  = '{4'b1111, 32'hD4C3A5B2, 0, 8'hB2, 1'b0};
    tbl[8]  = '{4'b0100, 32'hD4C3A5B2, 2, 8'hC3, 1'b0};
    tbl[9]  = '{4'b1001, 32'hD4C3A5B2, 3, 8'hD4, 1'b0};
    tbl[10] = '{4'b1001, 32'hD4C3A5B2, 0, 8'hB2, 1'b0};
    tbl[11] = '{4'b0001, 32'hD4C3A53C, 0, 8'h3C, 1'b1};
    #2;
    chk_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) run_frame(tbl[i]);
    req = 4'b0100;
    data = 32'hD4C3A5B2;
    w = 0;
    @(negedge clk);
    while (grant == 0 && w < 20) begin
      w++;
      @(negedge clk);
    end
    chk("abort_latency", w, 0);
    for (int k = 0; k < 6; k++) @(negedge clk);
    chk("abort_grant", grant, 4'b0100);
    chk("abort_valid", ser_valid, 1'b1);
    #1 rst = 1'b1;
    #1 chk_idle("abort_now");
    @(negedge clk);
    chk_idle("abort_nodone");
    rst = 1'b0;
    run_frame('{4'b1111, 32'hD4C3A5B2, 0, 8'hB2, 1'b0});
    req = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk_idle("idle");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    ptr_m = 0;
    for (int c = 0; c < 3000; c++) begin
      req = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
      data = $urandom;
      @(posedge clk);
      if (q.size() == 0 && req != 0) begin
        w = -1;
        for (int i = 0; i < NREQ; i++) begin
          n = (ptr_m + i) % NREQ;
          if (w < 0 && req[n]) w = n;
        end
        ptr_m = (w + 1) % NREQ;
        oh = 4'b1 << w;
        pay = data[w*DW +: DW];
        for (int k = 0; k < 3; k++) q.push_back(obs_t'({pre[k], 1'b1, oh, 4'b0, 1'b1}));
        for (int k = 0; k < DW; k++) q.push_back(obs_t'({pay[k], 1'b1, oh, 4'b0, 1'b1}));
        q.push_back(obs_t'({1'b1, 1'b0, oh, oh, 1'b1}));
        q.push_back(idle_o);
      end
      @(negedge clk);
      e = (q.size() != 0) ? q.pop_front() : idle_o;
      chk("random", {ser_out, ser_valid, grant, done, busy}, e);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
